// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         TIMEOUT_DEFAULT = 16;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EX_MEM load/store control into a req/ack
// transaction on a variable-latency data memory and stalls the pipeline meanwhile.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata_mem,
  output logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);

  state_t     state, next_state;
  logic [7:0] cnt;
  logic       acc;
  logic       aligned;

  assign acc     = mem_valid & (MemRead | MemWrite);
  assign aligned = is_word_aligned(alu_out);

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (aligned) begin
            stall      = 1'b1;
            next_state = REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack || (cnt == TIMEOUT_CNT)) next_state = DONE;
      end
      // DONE never evaluates a new access, so the finished instruction is not reissued
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_rdata <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (acc) begin
            if (aligned) begin
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= {alu_out[31:2], 2'b00};
              dmem_wdata <= wdata_in;
              cnt        <= 8'd0;
            end else begin
              dmem_rdata <= 32'd0;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            if (!dmem_we) dmem_rdata <= dmem_rdata_mem;
            dmem_req <= 1'b0;
          end else if (cnt == TIMEOUT_CNT) begin
            bus_err    <= 1'b1;
            dmem_rdata <= 32'd0;
            dmem_req   <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: a default-timeout instance for
// normal traffic and a TIMEOUT=4 instance for the abandoned-access case.
module tb_mem_access_ctrl;

  localparam int TO_A = 16;
  localparam int TO_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        mem_valid, MemRead, MemWrite;
  logic [31:0] alu_out, wdata_in, dmem_rdata_mem;
  logic        dmem_ack;

  logic        mv_a, mv_b;
  logic        req_a, we_a, stall_a, mis_a, berr_a;
  logic        req_b, we_b, stall_b, mis_b, berr_b;
  logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;

  logic        o_req, o_we, o_stall, o_mis, o_berr;
  logic [31:0] o_addr, o_wdata, o_rdata;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_rdata_a = 32'd0, model_rdata_b = 32'd0;
  logic        model_berr_a  = 1'b0,  model_berr_b  = 1'b0;

  always #5 clk = ~clk;

  assign mv_a = mem_valid & ~sel;
  assign mv_b = mem_valid & sel;

  assign o_req   = sel ? req_b   : req_a;
  assign o_we    = sel ? we_b    : we_a;
  assign o_stall = sel ? stall_b : stall_a;
  assign o_mis   = sel ? mis_b   : mis_a;
  assign o_berr  = sel ? berr_b  : berr_a;
  assign o_addr  = sel ? addr_b  : addr_a;
  assign o_wdata = sel ? wd_b    : wd_a;
  assign o_rdata = sel ? rd_b    : rd_a;

  mem_access_ctrl #(.TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .mem_valid(mv_a), .MemRead(MemRead), .MemWrite(MemWrite),
    .alu_out(alu_out), .wdata_in(wdata_in), .dmem_req(req_a), .dmem_we(we_a),
    .dmem_addr(addr_a), .dmem_wdata(wd_a), .dmem_ack(dmem_ack),
    .dmem_rdata_mem(dmem_rdata_mem), .dmem_rdata(rd_a), .stall(stall_a),
    .misaligned(mis_a), .bus_err(berr_a)
  );

  mem_access_ctrl #(.TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .mem_valid(mv_b), .MemRead(MemRead), .MemWrite(MemWrite),
    .alu_out(alu_out), .wdata_in(wdata_in), .dmem_req(req_b), .dmem_we(we_b),
    .dmem_addr(addr_b), .dmem_wdata(wd_b), .dmem_ack(dmem_ack),
    .dmem_rdata_mem(dmem_rdata_mem), .dmem_rdata(rd_b), .stall(stall_b),
    .misaligned(mis_b), .bus_err(berr_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One memory instruction held in EX_MEM until its DONE cycle; ack_after = 0 means never ack
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rmem, input int ack_after, input int timeout);
    logic [31:0] cur_rdata;
    logic        cur_berr, timed_out;
    int          exp_req, req_cycles, stall_cycles;
    cur_rdata    = sel ? model_rdata_b : model_rdata_a;
    cur_berr     = sel ? model_berr_b  : model_berr_a;
    req_cycles   = 0;
    stall_cycles = 0;

    @(posedge clk); #2;
    mem_valid = 1'b1; MemRead = rd; MemWrite = wr;
    alu_out = addr; wdata_in = wd; dmem_ack = 1'b0; dmem_rdata_mem = 32'hDEADBEEF;
    #1;

    if (addr[1:0] != 2'b00) begin
      checkOutput({tag, "/mis"}, 32'(o_mis), 32'd1);
      checkOutput({tag, "/mis_stall"}, 32'(o_stall), 32'd0);
      checkOutput({tag, "/mis_req"}, 32'(o_req), 32'd0);
      @(posedge clk); #2;
      mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      checkOutput({tag, "/mis_rdata"}, o_rdata, 32'd0);
      checkOutput({tag, "/mis_req_after"}, 32'(o_req), 32'd0);
      checkOutput({tag, "/mis_pulse_end"}, 32'(o_mis), 32'd0);
      if (sel) model_rdata_b = 32'd0; else model_rdata_a = 32'd0;
      return;
    end

    timed_out = (ack_after == 0) || (ack_after > timeout);
    exp_req   = timed_out ? timeout : ack_after;
    exp_q.push_back(timed_out ? 32'd0 : (wr ? cur_rdata : rmem));
    checkOutput({tag, "/req_c0"}, 32'(o_req), 32'd0);
    if (o_stall) stall_cycles++;

    for (int n = 1; n <= exp_req; n++) begin
      @(posedge clk); #2;
      dmem_ack       = (n == ack_after);
      dmem_rdata_mem = (n == ack_after) ? rmem : 32'hDEADBEEF;
      #1;
      if (o_req) req_cycles++;
      if (o_stall) stall_cycles++;
      checkOutput({tag, "/we"}, 32'(o_we), 32'(wr));
      checkOutput({tag, "/addr"}, o_addr, addr);
      checkOutput({tag, "/wdata"}, o_wdata, wd);
    end

    @(posedge clk); #2;
    dmem_ack = 1'b0; dmem_rdata_mem = 32'hDEADBEEF;
    #1;
    checkOutput({tag, "/req_cycles"}, 32'(req_cycles), 32'(exp_req));
    checkOutput({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(exp_req + 1));
    checkOutput({tag, "/done_stall"}, 32'(o_stall), 32'd0);
    checkOutput({tag, "/done_req"}, 32'(o_req), 32'd0);
    checkOutput({tag, "/done_rdata"}, o_rdata, exp_q.pop_front());
    checkOutput({tag, "/bus_err"}, 32'(o_berr), 32'(cur_berr | timed_out));
    if (sel) begin
      model_rdata_b = o_rdata === rd_b ? (timed_out ? 32'd0 : (wr ? cur_rdata : rmem)) : model_rdata_b;
      model_berr_b  = cur_berr | timed_out;
    end else begin
      model_rdata_a = timed_out ? 32'd0 : (wr ? cur_rdata : rmem);
      model_berr_a  = cur_berr | timed_out;
    end
  endtask

  task automatic idleCycle(input string tag, input logic ack);
    @(posedge clk); #2;
    mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    dmem_ack = ack; dmem_rdata_mem = 32'hBAD0BAD0;
    #1;
    checkOutput({tag, "/req"}, 32'(o_req), 32'd0);
    checkOutput({tag, "/stall"}, 32'(o_stall), 32'd0);
    checkOutput({tag, "/rdata"}, o_rdata, sel ? model_rdata_b : model_rdata_a);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel = 1'b0; mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    alu_out = 32'd0; wdata_in = 32'd0; dmem_ack = 1'b0; dmem_rdata_mem = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst/req", 32'(req_a), 32'd0);
    checkOutput("rst/we", 32'(we_a), 32'd0);
    checkOutput("rst/addr", addr_a, 32'd0);
    checkOutput("rst/wdata", wd_a, 32'd0);
    checkOutput("rst/rdata", rd_a, 32'd0);
    checkOutput("rst/bus_err", 32'(berr_a), 32'd0);
    checkOutput("rst/stall", 32'(stall_a), 32'd0);
    checkOutput("rst/mis", 32'(mis_a), 32'd0);
    #9 rst = 1'b0;

    $display("[TB] load with ack in first REQ cycle");
    applyStimulus("load40", 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678, 1, TO_A);
    idleCycle("idle1", 1'b0);

    $display("[TB] store acked after 5 cycles");
    applyStimulus("store80", 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0BADF00D, 5, TO_A);
    idleCycle("spurious_ack", 1'b1);
    idleCycle("idle2", 1'b0);

    $display("[TB] misaligned accesses");
    applyStimulus("misload41", 1'b1, 1'b0, 32'h41, 32'h0, 32'h11111111, 1, TO_A);
    idleCycle("idle3", 1'b0);
    applyStimulus("misstore82", 1'b0, 1'b1, 32'h82, 32'h22222222, 32'h0, 1, TO_A);

    $display("[TB] back-to-back loads and read-write collision");
    applyStimulus("b2b_0", 1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A5A5A5, 1, TO_A);
    applyStimulus("b2b_1", 1'b1, 1'b0, 32'h104, 32'h0, 32'h5A5A5A5A, 1, TO_A);
    applyStimulus("rdwr", 1'b1, 1'b1, 32'h108, 32'h33333333, 32'h44444444, 2, TO_A);
    idleCycle("idle4", 1'b0);

    $display("[TB] timeout on TIMEOUT=4 instance");
    sel = 1'b1;
    applyStimulus("timeout", 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 0, TO_B);
    idleCycle("idle5", 1'b0);
    applyStimulus("after_to", 1'b1, 1'b0, 32'h204, 32'h0, 32'h66666666, 2, TO_B);
    idleCycle("idle6", 1'b0);
    sel = 1'b0;
    #1;
    checkOutput("a_no_bus_err", 32'(berr_a), 32'd0);

    $display("[TB] reset in the middle of REQ");
    @(posedge clk); #2;
    mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; alu_out = 32'h300; dmem_ack = 1'b0;
    #1;
    checkOutput("rstreq/stall_c0", 32'(o_stall), 32'd1);
    @(posedge clk); #3;
    checkOutput("rstreq/req_on", 32'(o_req), 32'd1);
    #1;
    rst = 1'b1; mem_valid = 1'b0; MemRead = 1'b0;
    #1;
    checkOutput("rstreq/req_off", 32'(o_req), 32'd0);
    checkOutput("rstreq/stall", 32'(o_stall), 32'd0);
    checkOutput("rstreq/state", 32'(dut_a.state), 32'd0);
    model_rdata_a = 32'd0;
    @(posedge clk); #2;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata_mem = 32'h77777777;
    #1;
    checkOutput("rstreq/late_ack_req", 32'(o_req), 32'd0);
    @(posedge clk); #2;
    dmem_ack = 1'b0;
    #1;
    checkOutput("rstreq/late_ack_rdata", o_rdata, model_rdata_a);
    checkOutput("rstreq/late_ack_state", 32'(dut_a.state), 32'd0);
    checkOutput("rstreq/scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage controller between the EX_MEM pipeline register and a variable-latency data memory.
- Converts the EX_MEM load/store control into a req/ack memory transaction and stalls the upstream pipeline until the access completes.
- Delivers load data on dmem_rdata, which the MEM_WB register captures.
- Flags misaligned word accesses and memory timeouts.

Parameters:
- TIMEOUT, 16: REQ-state cycles without ack before the access is abandoned. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  EX_MEM holds a live instruction (not a bubble)
- MemRead  in  1  load word
- MemWrite  in  1  store word
- alu_out  in  32  byte address from EX_MEM
- wdata_in  in  32  store data from EX_MEM
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, valid while dmem_req = 1
- dmem_addr  out  32  word-aligned address, held while dmem_req = 1
- dmem_wdata  out  32  store data, held while dmem_req = 1
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata_mem  in  32  memory read data, valid with dmem_ack
- dmem_rdata  out  32  load result to MEM_WB
- stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM; MEM_WB inserts a bubble (RegWrite = 0)
- misaligned  out  1  one-cycle pulse: access suppressed, alu_out[1:0] != 0
- bus_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Access condition: acc = mem_valid & (MemRead | MemWrite). If both MemRead and MemWrite are set, the access is treated as a write.
- States: IDLE, REQ, DONE. 2-bit state; 8-bit counter cnt.
- IDLE, acc and alu_out[1:0] == 0:
  - stall = 1 (combinational).
  - Next edge: latch addr/wdata/we; dmem_req <= 1; cnt <= 0; go to REQ.
- IDLE, acc and alu_out[1:0] != 0:
  - stall = 0; misaligned = 1 that cycle (combinational); no request issued.
  - dmem_rdata <= 0 at the edge. The store is dropped.
- IDLE, !acc: stall = 0; outputs hold.
- REQ:
  - stall = 1; dmem_req, dmem_we, dmem_addr and dmem_wdata are stable.
  - On dmem_ack: if read, dmem_rdata <= dmem_rdata_mem; dmem_req <= 0; go to DONE.
  - Else if cnt == TIMEOUT-1: bus_err <= 1; dmem_rdata <= 0; dmem_req <= 0; go to DONE.
  - Else cnt <= cnt+1.
- DONE:
  - stall = 0. The instruction still sits in EX_MEM and advances into MEM_WB at this edge, with dmem_rdata valid.
  - Unconditionally go to IDLE. No new access is evaluated in DONE, so the completed instruction is never reissued.
- Minimum cost of a memory instruction: 2 stall cycles.
  - Cycle N: acc seen in IDLE.
  - Cycle N+1: req.
  - ack at N+1 gives DONE at N+2.
- Stores leave dmem_rdata unchanged.
- dmem_ack in IDLE or DONE is ignored. No state change, no data capture.
- Reset values (immediate, asynchronous):
  - state = IDLE, cnt = 0
  - dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0
  - dmem_rdata = 0, bus_err = 0
  - stall and misaligned are combinational and therefore 0 once state = IDLE.
- Reset mid-REQ drops dmem_req at once. The memory side must tolerate an abandoned request.
- A timeout does not halt the pipeline. bus_err stays asserted for the exception/debug logic.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2
  - WORD_ALIGN_MASK = 2'b11
  - TIMEOUT default
- No sub-module. A single FSM with its counter is natural at this size.

Test Plan:
- Load, ack in first REQ cycle: alu_out = 0x40, MemRead = 1, mem returns 0x12345678.
  - Required: stall = 1 for 2 cycles, dmem_req = 1 for exactly 1 cycle with dmem_addr = 0x40 and dmem_we = 0.
  - Required: in DONE, dmem_rdata = 0x12345678 and stall = 0.
- Store, ack after 5 cycles: alu_out = 0x80, wdata_in = 0xCAFEF00D, MemWrite = 1.
  - Required: dmem_req = 1 and dmem_we = 1 held for 5 cycles, addr/wdata stable throughout.
  - Required: stall = 1 for 6 cycles; dmem_rdata unchanged.
- Misaligned load: alu_out = 0x41, MemRead = 1.
  - Required: misaligned = 1 for one cycle, stall = 0, dmem_req never asserted, dmem_rdata = 0 next cycle.
- Timeout, TIMEOUT = 4, no ack.
  - Required: dmem_req = 1 for 4 cycles, then bus_err = 1 (remains 1 through later accesses), dmem_rdata = 0, one DONE cycle, back to IDLE.
- Back-to-back loads, each acked in the first REQ cycle.
  - Required: the second request starts only after DONE; no duplicate request for the first load.
  - Spurious dmem_ack in IDLE changes nothing.
- rst asserted in REQ mid-wait.
  - Required: dmem_req = 0, stall = 0 and state = IDLE immediately; a later ack is ignored.
